// File: rtl/lsu_pkg.sv
// Shared definitions for the NPC load/store port: size codes, FSM states and
// the latched request record.
package lsu_pkg;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_ILL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic        store;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: misalignment check, write mask and data shift,
// and load-data extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misalign,
    output logic [7:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] load_data
);

    logic [2:0]  nbytes;
    logic [4:0]  shamt;
    logic [31:0] rdata_sh;

    assign shamt    = {addr_lo, 3'b000};
    assign wdata_sh = wdata << shamt;
    assign rdata_sh = rdata >> shamt;

    always_comb begin
        misalign = 1'b0;
        nbytes   = 3'd0;
        case (size)
            SZ_B: nbytes = 3'd1;
            SZ_H: begin
                nbytes   = 3'd2;
                misalign = addr_lo[0];
            end
            SZ_W: begin
                nbytes   = 3'd4;
                misalign = (addr_lo != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

    // A lane is enabled when it falls inside [offset, offset + nbytes);
    // the upper four mask bits exist only for controller compatibility.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            if (gi < 4) begin : g_lane
                assign wmask[gi] = ({1'b0, addr_lo} <= 3'(gi)) &&
                                   (3'(gi) < ({1'b0, addr_lo} + nbytes));
            end else begin : g_pad
                assign wmask[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        load_data = rdata_sh;
        case (size)
            SZ_B: load_data = is_unsigned ? {24'd0, rdata_sh[7:0]}
                                          : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            SZ_H: load_data = is_unsigned ? {16'd0, rdata_sh[15:0]}
                                          : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_data = rdata_sh;
        endcase
    end

endmodule

// File: rtl/mem_lsu_port.sv
// Load/store initiator port: one outstanding access, valid/ready towards the
// memory controller, timeout-guarded wait for the response.
module mem_lsu_port
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    lsu_state_t    state_reg, state_next;
    lsu_req_t      req_reg, req_next, req_in;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic          err_reg, err_next;
    logic          ready_reg;

    logic [1:0]    sel_addr_lo;
    logic [1:0]    sel_size;
    logic          sel_unsigned;
    logic [31:0]   sel_wdata;
    logic          al_misalign;
    logic [7:0]    al_wmask;
    logic [31:0]   al_wdata;
    logic [31:0]   al_load;
    logic          accept;

    assign req_in = '{store:       req_store,
                      addr:        req_addr,
                      size:        req_size,
                      is_unsigned: req_unsigned,
                      wdata:       req_wdata};

    // In IDLE the aligner sees the incoming request so the misalignment
    // decision is made at acceptance; afterwards it works on the latched copy.
    always_comb begin
        if (state_reg == S_IDLE) begin
            sel_addr_lo  = req_addr[1:0];
            sel_size     = req_size;
            sel_unsigned = req_unsigned;
            sel_wdata    = req_wdata;
        end else begin
            sel_addr_lo  = req_reg.addr[1:0];
            sel_size     = req_reg.size;
            sel_unsigned = req_reg.is_unsigned;
            sel_wdata    = req_reg.wdata;
        end
    end

    lsu_align u_align (
        .addr_lo     (sel_addr_lo),
        .size        (sel_size),
        .is_unsigned (sel_unsigned),
        .wdata       (sel_wdata),
        .rdata       (mem_rdata),
        .misalign    (al_misalign),
        .wmask       (al_wmask),
        .wdata_sh    (al_wdata),
        .load_data   (al_load)
    );

    assign accept = req_valid && ready_reg;

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    req_next = req_in;
                    if (al_misalign) begin
                        state_next = S_RESP;
                        err_next   = 1'b1;
                        rdata_next = '0;
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_next = S_WAIT;
                    cnt_next   = '0;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_next = S_RESP;
                    err_next   = 1'b0;
                    rdata_next = req_reg.store ? 32'd0 : al_load;
                end else if (cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
                    state_next = S_RESP;
                    err_next   = 1'b1;
                    rdata_next = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                    err_next   = 1'b0;
                    rdata_next = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            req_reg   <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            ready_reg <= (state_next == S_IDLE);
        end
    end

    // Memory-side outputs are driven only while a request is on the bus.
    assign req_ready  = ready_reg;
    assign mem_valid  = (state_reg == S_REQ);
    assign mem_addr   = mem_valid ? {req_reg.addr[31:2], 2'b00} : 32'd0;
    assign mem_wen    = mem_valid && req_reg.store;
    assign mem_wdata  = mem_wen ? al_wdata : 32'd0;
    assign mem_wmask  = mem_valid ? al_wmask : 8'd0;
    assign resp_valid = (state_reg == S_RESP);
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;

endmodule

// File: tb/tb_mem_lsu_port.sv
// Directed bench for mem_lsu_port with TIMEOUT_CYC=4; expected values are
// hand-derived from the port's alignment and timing rules.
module tb_mem_lsu_port;
    import lsu_pkg::*;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks   = 0;
    int failures = 0;
    int mem_acc  = 0;
    int resp_acc = 0;

    mem_lsu_port #(.TIMEOUT_CYC(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_valid && mem_ready) mem_acc <= mem_acc + 1;
        if (resp_valid && resp_ready) resp_acc <= resp_acc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic st, input logic [31:0] a, input logic [1:0] sz,
                         input logic un, input logic [31:0] wd);
        req_store    = st;
        req_addr     = a;
        req_size     = sz;
        req_unsigned = un;
        req_wdata    = wd;
        req_valid    = 1'b1;
        tick();
        req_valid    = 1'b0;
    endtask

    task automatic mem_rsp(input logic [31:0] rd);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m0;
        int r0;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_addr     = 32'd0;
        req_size     = SZ_B;
        req_unsigned = 1'b0;
        req_wdata    = 32'd0;
        mem_ready    = 1'b1;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'd0;
        resp_ready   = 1'b1;

        // Reset state
        tick();
        tick();
        check_val("rst_req_ready", 32'(req_ready), 0);
        check_val("rst_mem_valid", 32'(mem_valid), 0);
        check_val("rst_mem_wmask", 32'(mem_wmask), 0);
        check_val("rst_resp_valid", 32'(resp_valid), 0);
        check_val("rst_resp_err", 32'(resp_err), 0);
        reset = 1'b1;
        tick();
        check_val("rel_req_ready", 32'(req_ready), 1);
        $display("TXN reset");

        // Store byte, zero-wait memory
        issue(1'b1, 32'h8000_0003, SZ_B, 1'b0, 32'h0000_00AB);
        check_val("sb_mem_valid", 32'(mem_valid), 1);
        check_val("sb_mem_addr", mem_addr, 32'h8000_0000);
        check_val("sb_mem_wdata", mem_wdata, 32'hAB00_0000);
        check_val("sb_mem_wmask", 32'(mem_wmask), 32'h08);
        check_val("sb_mem_wen", 32'(mem_wen), 1);
        check_val("sb_req_ready", 32'(req_ready), 0);
        check_val("sb_resp_n1", 32'(resp_valid), 0);
        tick();
        check_val("sb_wait_mem_valid", 32'(mem_valid), 0);
        check_val("sb_resp_n2", 32'(resp_valid), 0);
        mem_rsp(32'h5555_5555);
        check_val("sb_resp_n3", 32'(resp_valid), 1);
        check_val("sb_err", 32'(resp_err), 0);
        check_val("sb_rdata", resp_rdata, 0);
        tick();
        check_val("sb_done_resp", 32'(resp_valid), 0);
        check_val("sb_next_ready", 32'(req_ready), 1);
        $display("TXN store_byte addr=80000003");

        // Load half signed, then unsigned
        issue(1'b0, 32'h8000_0002, SZ_H, 1'b0, 32'd0);
        check_val("lh_mem_wmask", 32'(mem_wmask), 32'h0C);
        check_val("lh_mem_wen", 32'(mem_wen), 0);
        tick();
        mem_rsp(32'h8001_1234);
        check_val("lh_rdata", resp_rdata, 32'hFFFF_8001);
        check_val("lh_err", 32'(resp_err), 0);
        tick();
        $display("TXN load_half_signed addr=80000002");

        issue(1'b0, 32'h8000_0002, SZ_H, 1'b1, 32'd0);
        tick();
        mem_rsp(32'h8001_1234);
        check_val("lhu_rdata", resp_rdata, 32'h0000_8001);
        tick();
        $display("TXN load_half_unsigned addr=80000002");

        // Load byte signed from lane 1
        issue(1'b0, 32'h8000_0001, SZ_B, 1'b0, 32'd0);
        check_val("lb_mem_wmask", 32'(mem_wmask), 32'h02);
        tick();
        mem_rsp(32'h0000_8000);
        check_val("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        tick();
        $display("TXN load_byte_signed addr=80000001");

        // Misaligned word load: no memory access, immediate error
        m0 = mem_acc;
        issue(1'b0, 32'h8000_0001, SZ_W, 1'b0, 32'd0);
        check_val("mis_mem_valid", 32'(mem_valid), 0);
        check_val("mis_resp_valid", 32'(resp_valid), 1);
        check_val("mis_err", 32'(resp_err), 1);
        check_val("mis_rdata", resp_rdata, 0);
        tick();
        check_val("mis_after_mem_valid", 32'(mem_valid), 0);
        check_val("mis_mem_acc", 32'(mem_acc - m0), 0);
        $display("TXN misaligned_word addr=80000001");

        // Illegal size code at an aligned address
        issue(1'b0, 32'h8000_0000, SZ_ILL, 1'b0, 32'd0);
        check_val("ill_resp_valid", 32'(resp_valid), 1);
        check_val("ill_err", 32'(resp_err), 1);
        tick();
        $display("TXN illegal_size");

        // Backpressure on both sides
        m0 = mem_acc;
        r0 = resp_acc;
        mem_ready  = 1'b0;
        resp_ready = 1'b0;
        issue(1'b0, 32'h8000_0010, SZ_W, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_mem_valid", 32'(mem_valid), 1);
            check_val("bp_mem_addr", mem_addr, 32'h8000_0010);
            check_val("bp_mem_wmask", 32'(mem_wmask), 32'h0F);
            tick();
        end
        check_val("bp_mem_valid_hold", 32'(mem_valid), 1);
        mem_ready = 1'b1;
        tick();
        check_val("bp_wait_mem_valid", 32'(mem_valid), 0);
        mem_rsp(32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            check_val("bp_resp_valid", 32'(resp_valid), 1);
            check_val("bp_resp_rdata", resp_rdata, 32'hCAFE_F00D);
            check_val("bp_resp_err", 32'(resp_err), 0);
            tick();
        end
        check_val("bp_resp_valid_hold", 32'(resp_valid), 1);
        resp_ready = 1'b1;
        tick();
        check_val("bp_resp_done", 32'(resp_valid), 0);
        check_val("bp_mem_acc", 32'(mem_acc - m0), 1);
        check_val("bp_resp_acc", 32'(resp_acc - r0), 1);
        $display("TXN backpressure addr=80000010");

        // Timeout after exactly 4 WAIT cycles
        issue(1'b0, 32'h8000_0020, SZ_W, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_val("to_wait_resp_valid", 32'(resp_valid), 0);
            tick();
        end
        check_val("to_resp_valid", 32'(resp_valid), 1);
        check_val("to_err", 32'(resp_err), 1);
        check_val("to_rdata", resp_rdata, 0);
        tick();
        $display("TXN timeout addr=80000020");

        // rvalid on the 4th WAIT cycle wins over timeout
        issue(1'b0, 32'h8000_0020, SZ_W, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check_val("late_wait_resp_valid", 32'(resp_valid), 0);
            tick();
        end
        mem_rsp(32'h1234_5678);
        check_val("late_resp_valid", 32'(resp_valid), 1);
        check_val("late_err", 32'(resp_err), 0);
        check_val("late_rdata", resp_rdata, 32'h1234_5678);
        tick();
        $display("TXN rvalid_at_limit addr=80000020");

        // Reset during WAIT, stray rvalid afterwards
        issue(1'b0, 32'h8000_0030, SZ_W, 1'b0, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check_val("rw_req_ready_in_reset", 32'(req_ready), 0);
        reset = 1'b1;
        mem_rsp(32'hFFFF_FFFF);
        check_val("rw_resp_valid", 32'(resp_valid), 0);
        check_val("rw_mem_valid", 32'(mem_valid), 0);
        check_val("rw_mem_addr", mem_addr, 0);
        check_val("rw_mem_wmask", 32'(mem_wmask), 0);
        check_val("rw_resp_rdata", resp_rdata, 0);
        check_val("rw_resp_err", 32'(resp_err), 0);
        check_val("rw_req_ready", 32'(req_ready), 1);
        tick();
        check_val("rw_resp_valid_later", 32'(resp_valid), 0);
        $display("TXN reset_in_wait");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_lsu_port.md
# mem_lsu_port

Initiator-side load/store port of the NPC core. Accepts one load or store per transaction from the execute stage, performs alignment checks, converts the byte address and size into a word-aligned memory request with a byte write mask, and drives the request through a valid/ready handshake to the DPI-backed memory controller. It waits for the memory response, extracts and sign- or zero-extends load data, and returns a single response, with an error flag for misalignment or timeout.

## Interface
- `TIMEOUT_CYC`, default 255: maximum cycles spent in WAIT before an error response; must be at least 1.
- `clock`  input  1: sole clock.
- `reset`  input  1: synchronous, active-low (0 = reset), sampled on the rising edge of `clock`.
- `req_valid`  input  1: execute stage presents a request.
- `req_ready`  output  1: request accepted this cycle when high together with `req_valid`.
- `req_store`  input  1: 1 = store, 0 = load.
- `req_addr`  input  32: byte address.
- `req_size`  input  2: 0 = byte, 1 = half, 2 = word; 3 is illegal and reported as an error.
- `req_unsigned`  input  1: zero-extend the load result; otherwise sign-extend.
- `req_wdata`  input  32: store data, right-aligned.
- `mem_valid`  output  1: request to the memory controller.
- `mem_ready`  input  1: memory accepts the request.
- `mem_addr`  output  32: `req_addr` with bits [1:0] forced to 0.
- `mem_wen`  output  1: store request.
- `mem_wdata`  output  32: store data shifted left by 8×`addr[1:0]`.
- `mem_wmask`  output  8: byte mask shifted by `addr[1:0]`; bits [7:4] are always 0.
- `mem_rvalid`  input  1: memory response; also acts as the write acknowledge for stores.
- `mem_rdata`  input  32: raw word read.
- `resp_valid`  output  1: response available.
- `resp_ready`  input  1: consumer takes the response.
- `resp_rdata`  output  32: extended load data; 0 for stores and on error.
- `resp_err`  output  1: misalignment, illegal size, or timeout.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, RESP. `req_ready` is high only in IDLE.
- **IDLE:** on a handshake, latch the request fields.
  - Misaligned request (half with `addr[0]`=1, word with `addr[1:0]`≠0) or `size`=3: go to RESP with `resp_err`=1. No memory access is made.
  - Otherwise: go to REQ.
- **REQ:** `mem_valid`=1. The address, data and mask outputs stay stable until `mem_ready` is sampled high, then go to WAIT and clear the timeout counter.
- **WAIT:** the counter increments each cycle.
  - `mem_rvalid`: latch the extracted data, go to RESP with `err`=0.
  - Counter reaching `TIMEOUT_CYC`: go to RESP with `err`=1 and `rdata`=0.
  - `mem_rvalid` has priority over timeout when both occur in the same cycle.
- **RESP:** `resp_valid`=1 and the outputs are held stable. On `resp_ready`, return to IDLE.
- **Write mask:** byte = `0001`, half = `0011`, word = `1111`, each shifted left by `addr[1:0]`.
- **Load extraction:** take `mem_rdata >> (8×addr[1:0])`, keep the low 8, 16 or 32 bits, then extend per `req_unsigned`.
- `mem_rvalid` outside WAIT is ignored.

## Timing
- All registers reset when `reset`=0 at a clock edge: state IDLE, `req_ready`=0 during reset and 1 from the first cycle after release, all `mem_*` and `resp_*` outputs 0, counter 0.
- Reset asserted mid-transaction abandons it. A late `mem_rvalid` arriving after reset is ignored.
- Minimum latency with zero-wait memory:
  - request accepted at edge N;
  - `mem_valid` high in cycle N+1 (`mem_ready` high), WAIT at N+2;
  - `mem_rvalid` in N+2 gives `resp_valid` at N+3.
- A misaligned request gives `resp_valid` in the cycle after acceptance.
- Next `req_ready` is one cycle after the `resp_ready` handshake. There is no back-to-back overlap and at most one outstanding transaction.
- The timeout fires after exactly `TIMEOUT_CYC` WAIT cycles without `mem_rvalid`.

## Structure
- A shared package `lsu_pkg` holds:
  - the size encoding constants (`SZ_B`, `SZ_H`, `SZ_W`);
  - the FSM state enum;
  - a `lsu_req_t` struct (store, addr, size, unsigned, wdata).
- One sub-module, `lsu_align`: purely combinational mask/shift generation, load extraction/extension, and the misalignment check. The FSM and the timeout counter live in `mem_lsu_port`.

## Test plan
- Store byte: addr 0x80000003, wdata 0x000000AB, zero-wait memory -> `mem_addr` 0x80000000, `mem_wdata` 0xAB000000, `mem_wmask` 0x08, `resp_valid` at N+3 with err 0 and rdata 0.
- Load half signed: addr 0x80000002, `mem_rdata` 0x8001_1234 -> `resp_rdata` 0xFFFF8001. The same access with `req_unsigned`=1 -> 0x00008001.
- Misaligned word load at 0x80000001 -> `mem_valid` never asserts; `resp_valid` next cycle with `resp_err`=1 and rdata 0.
- Backpressure: `mem_ready` low for 5 cycles, then `resp_ready` low for 3 cycles -> REQ outputs and response held stable; exactly one memory access and one response.
- Timeout with `TIMEOUT_CYC`=4 and no `mem_rvalid` -> `resp_err`=1 after exactly 4 WAIT cycles. In a second run with `mem_rvalid` on the 4th WAIT cycle -> err 0 and data returned.
- Reset pulled low during WAIT, then a stray `mem_rvalid` arrives after release -> all outputs 0, state IDLE, `req_ready`=1, no `resp_valid`.
